// File: rtl/bus_pkg.sv
// Shared definitions for the two-master system bus arbiter: region map,
// chip-enable bit positions, error read data and arbiter state encoding.
package bus_pkg;

  // Each region spans two consecutive ADDR[31:28] nibbles.
  localparam logic [3:0] NIB_ROM   = 4'h0;
  localparam logic [3:0] NIB_SRAM  = 4'h2;
  localparam logic [3:0] NIB_UART  = 4'h4;
  localparam logic [3:0] NIB_TIMER = 4'h6;
  localparam logic [3:0] NIB_GPIO  = 4'h8;

  localparam int unsigned CE_ROM   = 0;
  localparam int unsigned CE_SRAM  = 1;
  localparam int unsigned CE_UART  = 2;
  localparam int unsigned CE_TIMER = 3;
  localparam int unsigned CE_GPIO  = 4;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side and slave-side signals of the shared bus arbiter.
interface bus_arbiter_if;

  logic        i_M0_REQ,   i_M1_REQ;
  logic [31:0] i_M0_ADDR,  i_M1_ADDR;
  logic [31:0] i_M0_WDATA, i_M1_WDATA;
  logic        i_M0_WE,    i_M1_WE;
  logic        i_M0_RE,    i_M1_RE;
  logic [1:0]  i_M0_HB,    i_M1_HB;
  logic [31:0] o_M0_RDATA, o_M1_RDATA;
  logic        o_M0_GNT,   o_M1_GNT;
  logic        o_M0_ERR,   o_M1_ERR;

  logic        o_BUS_REQ;
  logic [31:0] o_BUS_ADDR;
  logic [31:0] o_BUS_WDATA;
  logic        o_BUS_WE,   o_BUS_RE;
  logic [1:0]  o_BUS_HB;
  logic [7:0]  o_BUS_CE;
  logic [31:0] i_BUS_RDATA;
  logic        i_BUS_GNT;

  logic        o_OWNER;
  logic        o_BUSY;

  // Arbiter view.
  modport slave (
    input  i_M0_REQ, i_M1_REQ, i_M0_ADDR, i_M1_ADDR, i_M0_WDATA, i_M1_WDATA,
           i_M0_WE, i_M1_WE, i_M0_RE, i_M1_RE, i_M0_HB, i_M1_HB,
           i_BUS_RDATA, i_BUS_GNT,
    output o_M0_RDATA, o_M1_RDATA, o_M0_GNT, o_M1_GNT, o_M0_ERR, o_M1_ERR,
           o_BUS_REQ, o_BUS_ADDR, o_BUS_WDATA, o_BUS_WE, o_BUS_RE, o_BUS_HB,
           o_BUS_CE, o_OWNER, o_BUSY
  );

  // Environment view: masters plus slaves driving the arbiter.
  modport master (
    output i_M0_REQ, i_M1_REQ, i_M0_ADDR, i_M1_ADDR, i_M0_WDATA, i_M1_WDATA,
           i_M0_WE, i_M1_WE, i_M0_RE, i_M1_RE, i_M0_HB, i_M1_HB,
           i_BUS_RDATA, i_BUS_GNT,
    input  o_M0_RDATA, o_M1_RDATA, o_M0_GNT, o_M1_GNT, o_M0_ERR, o_M1_ERR,
           o_BUS_REQ, o_BUS_ADDR, o_BUS_WDATA, o_BUS_WE, o_BUS_RE, o_BUS_HB,
           o_BUS_CE, o_OWNER, o_BUSY
  );

endinterface

// File: rtl/bus_ce_decode.sv
// Combinational region decode: ADDR[31:28] to one-hot slave chip enable.
module bus_ce_decode
  import bus_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] ce_o
);

  always_comb begin
    ce_o = '0;
    case (nib_i[3:1])
      NIB_ROM[3:1]:   ce_o[CE_ROM]   = 1'b1;
      NIB_SRAM[3:1]:  ce_o[CE_SRAM]  = 1'b1;
      NIB_UART[3:1]:  ce_o[CE_UART]  = 1'b1;
      NIB_TIMER[3:1]: ce_o[CE_TIMER] = 1'b1;
      NIB_GPIO[3:1]:  ce_o[CE_GPIO]  = 1'b1;
      default:        ce_o = '0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with chip-enable decode, unmapped-address
// error and transaction timeout watchdog.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 256,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT,
  parameter int unsigned CNT_W     = $clog2(TIMEOUT + 1)
) (
  input  logic         i_CLK,
  input  logic         i_RST,
  bus_arbiter_if.slave bus
);

  logic [0:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        own;
  logic        sel_req, sel_we, sel_re;
  logic [31:0] sel_addr, sel_wdata;
  logic [1:0]  sel_hb;
  logic [7:0]  ce;
  logic        active, unmapped, timeout, err, done;
  logic [31:0] rdata;

  assign own = (state_q == ST_OWN);

  always_comb begin
    if (owner_q) begin
      sel_req   = bus.i_M1_REQ;
      sel_addr  = bus.i_M1_ADDR;
      sel_wdata = bus.i_M1_WDATA;
      sel_we    = bus.i_M1_WE;
      sel_re    = bus.i_M1_RE;
      sel_hb    = bus.i_M1_HB;
    end else begin
      sel_req   = bus.i_M0_REQ;
      sel_addr  = bus.i_M0_ADDR;
      sel_wdata = bus.i_M0_WDATA;
      sel_we    = bus.i_M0_WE;
      sel_re    = bus.i_M0_RE;
      sel_hb    = bus.i_M0_HB;
    end
  end

  bus_ce_decode u_ce_decode (
    .nib_i (sel_addr[31:28]),
    .ce_o  (ce)
  );

  // A slave grant beats the watchdog; an unmapped address has no slave to grant.
  assign active   = own && sel_req;
  assign unmapped = active && (cnt_q == '0) && (ce == '0);
  assign timeout  = active && (cnt_q == CNT_W'(TIMEOUT - 1)) && !bus.i_BUS_GNT;
  assign err      = unmapped || timeout;
  assign done     = err || (active && bus.i_BUS_GNT);
  assign rdata    = err ? ERR_RDATA : bus.i_BUS_RDATA;

  assign bus.o_M0_GNT   = done && !owner_q;
  assign bus.o_M1_GNT   = done && owner_q;
  assign bus.o_M0_ERR   = err && !owner_q;
  assign bus.o_M1_ERR   = err && owner_q;
  assign bus.o_M0_RDATA = (done && !owner_q) ? rdata : '0;
  assign bus.o_M1_RDATA = (done && owner_q) ? rdata : '0;

  assign bus.o_BUS_REQ   = active && !err;
  assign bus.o_BUS_ADDR  = active ? {4'h0, sel_addr[27:0]} : '0;
  assign bus.o_BUS_WDATA = active ? sel_wdata : '0;
  assign bus.o_BUS_WE    = active && sel_we;
  assign bus.o_BUS_RE    = active && sel_re;
  assign bus.o_BUS_HB    = active ? sel_hb : '0;
  assign bus.o_BUS_CE    = active ? ce : '0;
  assign bus.o_OWNER     = own && owner_q;
  assign bus.o_BUSY      = own;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.i_M0_REQ || bus.i_M1_REQ) begin
          state_d = ST_OWN;
          owner_d = (bus.i_M0_REQ && bus.i_M1_REQ) ? rr_q : bus.i_M1_REQ;
        end
      end
      ST_OWN: begin
        if (done || !sel_req) begin
          state_d = ST_IDLE;
          rr_d    = ~owner_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bus_arbiter_if bif ();

  bus_arbiter #(.TIMEOUT(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bif)
  );

  function automatic logic [146:0] outs();
    return {bif.o_M0_GNT, bif.o_M0_ERR, bif.o_M0_RDATA,
            bif.o_M1_GNT, bif.o_M1_ERR, bif.o_M1_RDATA,
            bif.o_BUS_REQ, bif.o_BUS_ADDR, bif.o_BUS_WDATA, bif.o_BUS_WE,
            bif.o_BUS_RE, bif.o_BUS_HB, bif.o_BUS_CE, bif.o_OWNER, bif.o_BUSY};
  endfunction

  // Regions are pairs of nibbles starting at 0; nibbles 10..15 are unmapped.
  function automatic logic [7:0] exp_ce(input logic [3:0] n);
    int unsigned v;
    v = (n < 4'd10) ? (32'd1 << (n / 2)) : 0;
    return 8'(v);
  endfunction

  task automatic idle_inputs();
    bif.i_M0_REQ = 0; bif.i_M0_ADDR = '0; bif.i_M0_WDATA = '0;
    bif.i_M0_WE = 0; bif.i_M0_RE = 0; bif.i_M0_HB = '0;
    bif.i_M1_REQ = 0; bif.i_M1_ADDR = '0; bif.i_M1_WDATA = '0;
    bif.i_M1_WE = 0; bif.i_M1_RE = 0; bif.i_M1_HB = '0;
    bif.i_BUS_GNT = 0; bif.i_BUS_RDATA = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    bif.i_M0_REQ = 1; bif.i_BUS_GNT = 1; bif.i_BUS_RDATA = 32'h5555_AAAA;
    @(negedge clk); #1;
    checks++;
    if (outs() !== '0) begin
      failures++; $display("FAIL reset_during act=%h exp=0", outs());
    end
    idle_inputs();
    rst = 0;
    @(negedge clk); #1;
    checks++;
    if (outs() !== '0) begin
      failures++; $display("FAIL reset_after act=%h exp=0", outs());
    end
  endtask

  task automatic test_single_read();
    logic [33:0] exp;
    @(negedge clk);
    bif.i_M0_REQ = 1; bif.i_M0_ADDR = 32'h2000_0010; bif.i_M0_RE = 1; bif.i_M0_HB = 2'd2;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bif.i_BUS_GNT = (k == 3);
      bif.i_BUS_RDATA = (k == 3) ? 32'h1234_5678 : 32'h0BAD_0BAD;
      #1;
      checks++;
      if ({bif.o_BUS_REQ, bif.o_BUS_CE, bif.o_BUS_ADDR, bif.o_BUSY, bif.o_OWNER}
          !== {1'b1, 8'h02, 32'h0000_0010, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL single_bus k=%0d act req=%b ce=%h addr=%h busy=%b own=%b exp 1 02 00000010 1 0",
                 k, bif.o_BUS_REQ, bif.o_BUS_CE, bif.o_BUS_ADDR, bif.o_BUSY, bif.o_OWNER);
      end
      exp = {(k == 3), 1'b0, (k == 3) ? 32'h1234_5678 : 32'h0};
      checks++;
      if ({bif.o_M0_GNT, bif.o_M0_ERR, bif.o_M0_RDATA} !== exp || bif.o_M1_GNT !== 1'b0) begin
        failures++;
        $display("FAIL single_gnt k=%0d act=%h/%b exp=%h/0", k,
                 {bif.o_M0_GNT, bif.o_M0_ERR, bif.o_M0_RDATA}, bif.o_M1_GNT, exp);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (outs() !== '0) begin
      failures++; $display("FAIL single_idle act=%h exp=0", outs());
    end
  endtask

  task automatic test_fairness();
    bit rr;
    int exp_owner;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    bif.i_M0_REQ = 1; bif.i_M0_ADDR = 32'h0000_0100; bif.i_M0_RE = 1;
    bif.i_M1_REQ = 1; bif.i_M1_ADDR = 32'h3000_0200; bif.i_M1_WE = 1;
    bif.i_BUS_GNT = 1;
    rr = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bif.i_BUS_RDATA = 32'h1000_0000 + c;
      #1;
      checks++;
      if (c % 2 == 1) begin
        if (bif.o_BUSY !== 1'b0 || bif.o_M0_GNT !== 1'b0 || bif.o_M1_GNT !== 1'b0) begin
          failures++;
          $display("FAIL fair_bubble c=%0d act busy=%b g0=%b g1=%b exp 0 0 0",
                   c, bif.o_BUSY, bif.o_M0_GNT, bif.o_M1_GNT);
        end
      end else begin
        exp_owner = int'(rr);
        if ({bif.o_BUSY, bif.o_OWNER, bif.o_M0_GNT, bif.o_M1_GNT, bif.o_BUS_CE,
             (exp_owner == 0) ? bif.o_M0_RDATA : bif.o_M1_RDATA}
            !== {1'b1, rr, !rr, rr, (exp_owner == 0) ? 8'h01 : 8'h02, 32'h1000_0000 + c}) begin
          failures++;
          $display("FAIL fair_grant c=%0d act busy=%b own=%b g0=%b g1=%b ce=%h exp owner=%0d",
                   c, bif.o_BUSY, bif.o_OWNER, bif.o_M0_GNT, bif.o_M1_GNT, bif.o_BUS_CE, exp_owner);
        end
        rr = ~rr;
      end
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    bif.i_M1_REQ = 1; bif.i_M1_ADDR = 32'hA000_0000; bif.i_M1_WE = 1;
    bif.i_M1_WDATA = 32'h0000_00FF;
    @(negedge clk); #1;
    checks++;
    if ({bif.o_M1_GNT, bif.o_M1_ERR, bif.o_M1_RDATA, bif.o_BUS_REQ, bif.o_BUS_CE, bif.o_M0_GNT}
        !== {1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL unmapped act g=%b e=%b rd=%h req=%b ce=%h g0=%b exp 1 1 deadbeef 0 00 0",
               bif.o_M1_GNT, bif.o_M1_ERR, bif.o_M1_RDATA, bif.o_BUS_REQ, bif.o_BUS_CE, bif.o_M0_GNT);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (outs() !== '0) begin
      failures++; $display("FAIL unmapped_idle act=%h exp=0", outs());
    end
  endtask

  task automatic test_timeout();
    bif.i_M0_REQ = 1; bif.i_M0_ADDR = 32'h4000_0004; bif.i_M0_RE = 1;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      if (k == TO) begin
        bif.i_M1_REQ = 1; bif.i_M1_ADDR = 32'h6000_0000; bif.i_M1_RE = 1;
      end
      #1;
      checks++;
      if ({bif.o_M0_GNT, bif.o_M0_ERR, bif.o_M0_RDATA, bif.o_BUS_REQ, bif.o_BUS_CE}
          !== {(k == TO), (k == TO), (k == TO) ? 32'hDEAD_BEEF : 32'h0, (k != TO), 8'h04}) begin
        failures++;
        $display("FAIL timeout k=%0d act g=%b e=%b rd=%h req=%b ce=%h", k,
                 bif.o_M0_GNT, bif.o_M0_ERR, bif.o_M0_RDATA, bif.o_BUS_REQ, bif.o_BUS_CE);
      end
    end
    @(negedge clk);
    bif.i_M0_REQ = 0;
    #1;
    checks++;
    if (bif.o_BUSY !== 1'b0) begin
      failures++; $display("FAIL timeout_idle act busy=%b exp 0", bif.o_BUSY);
    end
    @(negedge clk);
    bif.i_BUS_GNT = 1; bif.i_BUS_RDATA = 32'h0000_7777;
    #1;
    checks++;
    if ({bif.o_M1_GNT, bif.o_M1_ERR, bif.o_M1_RDATA, bif.o_OWNER, bif.o_BUS_CE}
        !== {1'b1, 1'b0, 32'h0000_7777, 1'b1, 8'h08}) begin
      failures++;
      $display("FAIL timeout_next act g=%b e=%b rd=%h own=%b ce=%h exp 1 0 00007777 1 08",
               bif.o_M1_GNT, bif.o_M1_ERR, bif.o_M1_RDATA, bif.o_OWNER, bif.o_BUS_CE);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_gnt_at_timeout();
    bif.i_M1_REQ = 1; bif.i_M1_ADDR = 32'h8000_0040; bif.i_M1_RE = 1;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      bif.i_BUS_GNT = (k == TO);
      bif.i_BUS_RDATA = 32'hCAFE_F00D;
      #1;
      checks++;
      if ({bif.o_M1_GNT, bif.o_M1_ERR, bif.o_M1_RDATA, bif.o_BUS_REQ, bif.o_BUS_CE}
          !== {(k == TO), 1'b0, (k == TO) ? 32'hCAFE_F00D : 32'h0, 1'b1, 8'h10}) begin
        failures++;
        $display("FAIL gnt_at_timeout k=%0d act g=%b e=%b rd=%h req=%b ce=%h", k,
                 bif.o_M1_GNT, bif.o_M1_ERR, bif.o_M1_RDATA, bif.o_BUS_REQ, bif.o_BUS_CE);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_drop_req();
    bif.i_M0_REQ = 1; bif.i_M0_ADDR = 32'h2000_0000; bif.i_M0_RE = 1;
    @(negedge clk);
    bif.i_M0_REQ = 0;
    #1;
    checks++;
    if ({bif.o_BUSY, bif.o_M0_GNT, bif.o_BUS_REQ} !== 3'b100) begin
      failures++;
      $display("FAIL drop_own act busy=%b g=%b req=%b exp 1 0 0", bif.o_BUSY, bif.o_M0_GNT, bif.o_BUS_REQ);
    end
    @(negedge clk);
    bif.i_M0_REQ = 1; bif.i_M1_REQ = 1; bif.i_M1_ADDR = 32'h0000_0008; bif.i_M1_RE = 1;
    bif.i_BUS_GNT = 1; bif.i_BUS_RDATA = 32'h0000_0001;
    #1;
    checks++;
    if ({bif.o_BUSY, bif.o_M0_GNT} !== 2'b00) begin
      failures++; $display("FAIL drop_idle act busy=%b g=%b exp 0 0", bif.o_BUSY, bif.o_M0_GNT);
    end
    @(negedge clk); #1;
    checks++;
    if ({bif.o_OWNER, bif.o_M1_GNT, bif.o_M0_GNT} !== 3'b110) begin
      failures++;
      $display("FAIL drop_rr act own=%b g1=%b g0=%b exp 1 1 0", bif.o_OWNER, bif.o_M1_GNT, bif.o_M0_GNT);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bif.i_M0_REQ = 1; bif.i_M0_ADDR = 32'h2000_0000; bif.i_M0_RE = 1;
    repeat (3) @(negedge clk);
    rst = 1;
    bif.i_M1_REQ = 1; bif.i_M1_ADDR = 32'h0000_0020; bif.i_M1_RE = 1; bif.i_BUS_GNT = 1;
    #1;
    checks++;
    if (outs() !== '0) begin
      failures++; $display("FAIL reset_mid act=%h exp=0", outs());
    end
    @(negedge clk); #1;
    checks++;
    if (outs() !== '0) begin
      failures++; $display("FAIL reset_hold act=%h exp=0", outs());
    end
    bif.i_M0_REQ = 0; bif.i_BUS_GNT = 0;
    rst = 0;
    @(negedge clk); #1;
    checks++;
    if ({bif.o_BUSY, bif.o_OWNER, bif.o_M1_GNT, bif.o_M1_ERR, bif.o_M0_GNT, bif.o_M0_ERR, bif.o_BUS_REQ}
        !== 7'b1100001) begin
      failures++;
      $display("FAIL reset_retry act busy=%b own=%b g1=%b e1=%b g0=%b e0=%b req=%b exp 1 1 0 0 0 0 1",
               bif.o_BUSY, bif.o_OWNER, bif.o_M1_GNT, bif.o_M1_ERR, bif.o_M0_GNT, bif.o_M0_ERR, bif.o_BUS_REQ);
    end
    @(negedge clk);
    bif.i_BUS_GNT = 1; bif.i_BUS_RDATA = 32'h0000_ABCD;
    #1;
    checks++;
    if ({bif.o_M1_GNT, bif.o_M1_ERR, bif.o_M1_RDATA} !== {1'b1, 1'b0, 32'h0000_ABCD}) begin
      failures++;
      $display("FAIL reset_retry_gnt act g=%b e=%b rd=%h exp 1 0 0000abcd",
               bif.o_M1_GNT, bif.o_M1_ERR, bif.o_M1_RDATA);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // Transaction-level model: a winner is picked when the bus is free, each
  // transaction completes on its slave latency, the watchdog, or an unmapped address.
  task automatic test_random();
    int owner, k, lat;
    bit rr, gnt, mapped, e_err, e_done;
    bit req [2];
    logic [31:0] addr [2];
    logic [31:0] wd [2];
    bit we [2];
    logic [1:0] hb [2];
    logic [31:0] srd, e_rd;
    logic [146:0] exp;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    owner = -1; rr = 0; k = 0; lat = 0; mapped = 0; e_err = 0; e_done = 0;
    for (int m = 0; m < 2; m++) begin
      req[m] = 0; addr[m] = '0; wd[m] = '0; we[m] = 0; hb[m] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!req[m] && $urandom_range(0, 1) == 1) begin
          req[m] = 1;
          addr[m] = {4'($urandom_range(0, 11)), 28'($urandom)};
          wd[m] = $urandom;
          we[m] = 1'($urandom_range(0, 1));
          hb[m] = 2'($urandom_range(0, 3));
        end
      end
      if (owner >= 0) begin
        k++;
        mapped = addr[owner][31:28] < 4'd10;
        gnt = mapped && (k == lat);
      end else begin
        gnt = 1'($urandom_range(0, 1));
      end
      srd = $urandom;
      bif.i_M0_REQ = req[0]; bif.i_M0_ADDR = addr[0]; bif.i_M0_WDATA = wd[0];
      bif.i_M0_WE = we[0]; bif.i_M0_RE = ~we[0]; bif.i_M0_HB = hb[0];
      bif.i_M1_REQ = req[1]; bif.i_M1_ADDR = addr[1]; bif.i_M1_WDATA = wd[1];
      bif.i_M1_WE = we[1]; bif.i_M1_RE = ~we[1]; bif.i_M1_HB = hb[1];
      bif.i_BUS_GNT = gnt; bif.i_BUS_RDATA = srd;
      #1;
      exp = '0;
      if (owner >= 0) begin
        e_err = mapped ? (k == TO && !gnt) : (k == 1);
        e_done = e_err || gnt;
        e_rd = e_err ? 32'hDEAD_BEEF : srd;
        exp = {owner == 0 && e_done, owner == 0 && e_err, (owner == 0 && e_done) ? e_rd : 32'h0,
               owner == 1 && e_done, owner == 1 && e_err, (owner == 1 && e_done) ? e_rd : 32'h0,
               !e_err, {4'h0, addr[owner][27:0]}, wd[owner], we[owner], ~we[owner], hb[owner],
               exp_ce(addr[owner][31:28]), owner == 1, 1'b1};
      end
      checks++;
      if (outs() !== exp) begin
        failures++;
        $display("FAIL random c=%0d owner=%0d k=%0d act=%h exp=%h", c, owner, k, outs(), exp);
      end
      if (owner < 0) begin
        if (req[0] || req[1]) begin
          owner = (req[0] && req[1]) ? int'(rr) : (req[1] ? 1 : 0);
          k = 0;
          lat = $urandom_range(1, TO + 2);
        end
      end else if (e_done) begin
        req[owner] = 0;
        rr = (owner == 0);
        owner = -1;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_unmapped();
    test_timeout();
    test_gnt_at_timeout();
    test_drop_req();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter for the shared system bus. Master 0 is the core data port; master 1 is a DMA or debug master.
- Grants one master at a time using round-robin, then drives the shared BUS_* lines and decodes chip enables from ADDR[31:28].
- Routes slave GNT/RDATA back to the owner.
- A bus-timeout watchdog and unmapped-address detection return an error grant so no master hangs.

Parameters:
- TIMEOUT, 256: cycles a granted transaction may wait for i_BUS_GNT before an error completion; legal range 2..65535.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on any error completion.
- CNT_W, $clog2(TIMEOUT+1): timeout counter width; derived, do not override.

Ports:
- i_CLK  in  1  system clock
- i_RST  in  1  asynchronous, active-high reset
- i_M0_REQ, i_M1_REQ  in  1  master request; held until that master's GNT
- i_M0_ADDR, i_M1_ADDR  in  32  byte address
- i_M0_WDATA, i_M1_WDATA  in  32  write data
- i_M0_WE/i_M0_RE, i_M1_WE/i_M1_RE  in  1  write / read strobe
- i_M0_HB, i_M1_HB  in  2  access size
- o_M0_RDATA, o_M1_RDATA  out  32  read data, valid in the GNT cycle
- o_M0_GNT, o_M1_GNT  out  1  one-cycle completion pulse
- o_M0_ERR, o_M1_ERR  out  1  error qualifier, only asserted together with GNT
- o_BUS_REQ  out  1  shared request
- o_BUS_ADDR  out  32  {4'h0, owner ADDR[27:0]}
- o_BUS_WDATA  out  32  owner WDATA
- o_BUS_WE, o_BUS_RE  out  1  owner strobes
- o_BUS_HB  out  2  owner access size
- o_BUS_CE  out  8  one-hot slave enable
- i_BUS_RDATA  in  32  slave read data
- i_BUS_GNT  in  1  OR of slave grants
- o_OWNER  out  1  current owner index, valid while busy
- o_BUSY  out  1  transaction in flight

Behaviour:
- States: IDLE, OWN.
- Reset (async, i_RST=1): state=IDLE, rr pointer=0 (M0 preferred), counter=0.
  - All outputs are 0 during and after reset. Every output is a combinational function of state, so IDLE implies all zero.
- Arbitration in IDLE:
  - Only M0 requesting: grant M0. Only M1 requesting: grant M1.
  - Both requesting: the master indicated by the rr pointer wins.
  - On the clock edge the state moves to OWN and the owner is registered.
  - Latency: REQ seen at edge N; BUS_* is driven from cycle N+1.
- In OWN:
  - o_BUS_* = owner's inputs, gated by owner REQ.
  - o_BUS_CE decode on owner ADDR[31:28]: 0/1 -> bit0 (ROM), 2/3 -> bit1 (SRAM), 4/5 -> bit2 (UART), 6/7 -> bit3 (TIMER), 8/9 -> bit4 (GPIO), otherwise 8'h00.
  - Counter increments every OWN cycle.
- Normal completion: i_BUS_GNT=1 causes, in the same cycle:
  - o_Mx_GNT=1 and o_Mx_RDATA=i_BUS_RDATA for the owner;
  - the non-owner sees GNT=0 and RDATA=0.
  - Next state is IDLE, the rr pointer is set to ~owner, and the counter clears.
- Unmapped completion: CE==0 in the first OWN cycle causes:
  - owner GNT=1, ERR=1, RDATA=ERR_RDATA;
  - o_BUS_REQ=0 in that cycle;
  - next state IDLE.
- Timeout: counter==TIMEOUT-1 with no i_BUS_GNT causes:
  - owner GNT=1, ERR=1, RDATA=ERR_RDATA;
  - o_BUS_REQ forced to 0 in that cycle;
  - next state IDLE.
- Simultaneous i_BUS_GNT and timeout: GNT wins, no ERR, slave data is returned.
- Owner drops REQ while in OWN (protocol violation): return to IDLE next edge with no GNT; the rr pointer still flips.
- Throughput: there is always exactly one IDLE bubble between transactions. Maximum rate is one transaction per 2 cycles plus slave latency.
- Fairness: with both masters requesting continuously, grants alternate M0, M1, M0, and so on. Starvation is impossible.
- i_BUS_GNT while in IDLE is ignored.
- Reset asserted mid-transaction: immediate IDLE and all outputs 0. The master retries after reset.

Decomposition:
- Shared package bus_pkg holds:
  - region nibble constants and CE bit indices (ROM=0, SRAM=1, UART=2, TIMER=3, GPIO=4);
  - the default ERR_RDATA;
  - the arbiter state encoding localparams.
- One natural sub-module: bus_ce_decode (combinational ADDR[31:28] -> 8-bit CE). Reusing it keeps the region map in a single place.

Test Plan:
- Reset, then M0 reads 32'h2000_0010 while the slave asserts GNT 2 cycles later with RDATA 32'h1234_5678 -> o_BUS_CE=8'h02 and o_BUS_ADDR=32'h0000_0010; o_M0_GNT pulses once with that data; ERR=0.
- M0 and M1 both request continuously with a 1-cycle slave -> grant order M0, M1, M0, M1; exactly one IDLE cycle between grants; o_OWNER matches.
- M1 writes to 32'hA000_0000 -> CE=0; o_M1_GNT=1 and o_M1_ERR=1 in the first OWN cycle; RDATA=32'hDEAD_BEEF; o_BUS_REQ stays 0.
- M0 accesses the UART with the slave never granting, TIMEOUT=8 -> GNT+ERR on the 8th OWN cycle; state returns to IDLE; a following M1 request is served.
- Slave GNT arrives in exactly the timeout cycle -> normal GNT, ERR=0, slave RDATA returned.
- i_RST asserted mid-OWN, then released with M1 requesting -> all outputs 0 during reset; after release M1 is granted without stale GNT/ERR.
